// File: rtl/mult_share_sched_if.sv
// Bundle of the requester, result and datapath-control signals of the shared
// nibble-serial multiplier sequencer.
// slave  : seen from the sequencer (mult_share_sched)
// master : seen from the requesters, the result consumer and the datapath
interface mult_share_sched_if #(
  parameter int OP_W = 8
);
  // requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_a;
  logic [OP_W-1:0]   req0_b;
  // requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_a;
  logic [OP_W-1:0]   req1_b;
  // datapath control
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              sela;
  logic              selb;
  logic [1:0]        sel_shift;
  logic              data_sel;
  logic              acc_en;
  logic [2*OP_W-1:0] acc_q;
  // result port
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [2*OP_W-1:0] res_data;
  // status
  logic              busy;
  logic [2:0]        state;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  acc_q, res_ready,
    output req0_ready, req1_ready,
    output op_a, op_b, sela, selb, sel_shift, data_sel, acc_en,
    output res_valid, res_id, res_data,
    output busy, state
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output acc_q, res_ready,
    input  req0_ready, req1_ready,
    input  op_a, op_b, sela, selb, sel_shift, data_sel, acc_en,
    input  res_valid, res_id, res_data,
    input  busy, state
  );
endinterface

// File: rtl/mult_share_sched.sv
// Sequencer/arbiter for the shared nibble-serial 8x8 multiply datapath.
// Two requesters compete for the datapath; the winner's operands are latched
// and four partial-product steps (aL*bL, aH*bL<<4, aL*bH<<4, aH*bH<<8) are
// driven into the external accumulator. The product is then offered on the
// result port together with the owning requester ID.
// Optional feature macro: ZERO_SKIP_EN -- when defined, an accepted operation
// with a zero operand skips the four steps and returns 16'h0000 directly.
module mult_share_sched #(
  parameter int ROUND_ROBIN = 1,
  parameter int OP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  mult_share_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP0  = 3'd1,
    STEP1  = 3'd2,
    STEP2  = 3'd3,
    STEP3  = 3'd4,
    RESULT = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic            ptr_reg, ptr_next;       // 1 = req1 favoured on contention
  logic [OP_W-1:0] op_a_reg, op_a_next;
  logic [OP_W-1:0] op_b_reg, op_b_next;
  logic            id_reg, id_next;
`ifdef ZERO_SKIP_EN
  logic            zero_reg, zero_next;     // current product is known to be 0
  logic            grant_zero;
`endif

  logic            grant0, grant1;
  logic            accept;
  logic [OP_W-1:0] grant_a, grant_b;

  // Arbitration: only in IDLE and out of reset; ready goes to the grantee only
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && (state_reg == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if ((ROUND_ROBIN != 0) && ptr_reg) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign accept         = grant0 | grant1;
  assign grant_a        = grant1 ? bus.req1_a : bus.req0_a;
  assign grant_b        = grant1 ? bus.req1_b : bus.req0_b;
`ifdef ZERO_SKIP_EN
  assign grant_zero     = (grant_a == '0) || (grant_b == '0);
`endif

  // State and latch registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      id_reg    <= 1'b0;
`ifdef ZERO_SKIP_EN
      zero_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      id_reg    <= id_next;
`ifdef ZERO_SKIP_EN
      zero_reg  <= zero_next;
`endif
    end
  end

  // Next-state logic: accept in IDLE, run four fixed steps, wait for consumer
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    id_next    = id_reg;
`ifdef ZERO_SKIP_EN
    zero_next  = zero_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_a_next  = grant_a;
          op_b_next  = grant_b;
          id_next    = grant1;
          state_next = STEP0;
          // after a grant the other requester is favoured next time
          if (ROUND_ROBIN != 0) begin
            ptr_next = grant0;
          end
`ifdef ZERO_SKIP_EN
          zero_next = grant_zero;
          if (grant_zero) begin
            state_next = RESULT;
          end
`endif
        end
      end
      STEP0:   state_next = STEP1;
      STEP1:   state_next = STEP2;
      STEP2:   state_next = STEP3;
      STEP3:   state_next = RESULT;
      RESULT: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath control and result outputs decoded from the current state
  always_comb begin
    bus.sela      = 1'b0;
    bus.selb      = 1'b0;
    bus.sel_shift = 2'd0;
    bus.data_sel  = 1'b0;
    bus.acc_en    = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_id    = 1'b0;
    bus.res_data  = '0;
    case (state_reg)
      STEP0: begin
        bus.acc_en    = 1'b1;
      end
      STEP1: begin
        bus.acc_en    = 1'b1;
        bus.sela      = 1'b1;
        bus.sel_shift = 2'd1;
        bus.data_sel  = 1'b1;
      end
      STEP2: begin
        bus.acc_en    = 1'b1;
        bus.selb      = 1'b1;
        bus.sel_shift = 2'd1;
        bus.data_sel  = 1'b1;
      end
      STEP3: begin
        bus.acc_en    = 1'b1;
        bus.sela      = 1'b1;
        bus.selb      = 1'b1;
        bus.sel_shift = 2'd2;
        bus.data_sel  = 1'b1;
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        bus.res_id    = id_reg;
`ifdef ZERO_SKIP_EN
        bus.res_data  = zero_reg ? '0 : bus.acc_q;
`else
        bus.res_data  = bus.acc_q;
`endif
      end
      default: begin
      end
    endcase
  end

  assign bus.op_a  = op_a_reg;
  assign bus.op_b  = op_b_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.state = state_reg;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: a round-robin instance exercised with directed
// and random traffic against a transaction-level model, plus a fixed-priority
// instance checked for req1 starvation. Both instances get an external
// accumulator datapath model. Honours ZERO_SKIP_EN when defined.
module tb_mult_share_sched;

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rst_fx;
  int   checks = 0;
  int   errors = 0;
  bit   fx_done = 1'b0;

  always #5 clk = ~clk;

  mult_share_sched_if #(.OP_W(8)) bus_rr ();
  mult_share_sched_if #(.OP_W(8)) bus_fx ();

  mult_share_sched #(.ROUND_ROBIN(1), .OP_W(8)) dut_rr (.clk(clk), .rst(rst),    .bus(bus_rr));
  mult_share_sched #(.ROUND_ROBIN(0), .OP_W(8)) dut_fx (.clk(clk), .rst(rst_fx), .bus(bus_fx));

  // shared datapath: nibble mux, 4x4 multiply, shift, add, accumulator register
  function automatic logic [15:0] pp(input logic [7:0] a, input logic [7:0] b,
                                     input logic sa, input logic sb, input logic [1:0] sh);
    logic [15:0] na, nb;
    na = {12'h000, (sa ? a[7:4] : a[3:0])};
    nb = {12'h000, (sb ? b[7:4] : b[3:0])};
    return (na * nb) << (4 * sh);
  endfunction

  logic [15:0] acc_rr = 16'h0000;
  logic [15:0] acc_fx = 16'h0000;
  assign bus_rr.acc_q = acc_rr;
  assign bus_fx.acc_q = acc_fx;

  always_ff @(posedge clk) begin
    if (bus_rr.acc_en)
      acc_rr <= (bus_rr.data_sel ? acc_rr : 16'h0000)
                + pp(bus_rr.op_a, bus_rr.op_b, bus_rr.sela, bus_rr.selb, bus_rr.sel_shift);
    if (bus_fx.acc_en)
      acc_fx <= (bus_fx.data_sel ? acc_fx : 16'h0000)
                + pp(bus_fx.op_a, bus_fx.op_b, bus_fx.sela, bus_fx.selb, bus_fx.sel_shift);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one complete operation on the round-robin instance; starts and ends at a negedge
  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] data, output logic rid, output int lat);
    int n;
    n = 0; data = '0; rid = 1'b0; lat = 0;
    if (id == 1'b0) begin
      bus_rr.req0_valid = 1'b1; bus_rr.req0_a = a; bus_rr.req0_b = b;
    end else begin
      bus_rr.req1_valid = 1'b1; bus_rr.req1_a = a; bus_rr.req1_b = b;
    end
    #1;
    while (!(id ? bus_rr.req1_ready : bus_rr.req0_ready) && n <= 40) begin
      @(negedge clk); #1; n++;
    end
    if (n > 40) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
    lat = 1;
    while (!bus_rr.res_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    data = bus_rr.res_data;
    rid  = bus_rr.res_id;
    bus_rr.res_ready = 1'b1;
    @(negedge clk);
    bus_rr.res_ready = 1'b0;
    $display("op id=%0d a=%02h b=%02h -> data=%04h rid=%0d lat=%0d", id, a, b, data, rid, lat);
  endtask

  // wait (bounded) for the pending result, compare and consume it
  task automatic finish_result(input string tag, input logic [15:0] exp_data, input logic exp_id);
    int n;
    n = 0;
    #1;
    while (!bus_rr.res_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_valid"}, bus_rr.res_valid, 1);
    check({tag, "_data"},  bus_rr.res_data,  exp_data);
    check({tag, "_id"},    bus_rr.res_id,    exp_id);
    $display("op %s -> data=%04h rid=%0d", tag, bus_rr.res_data, bus_rr.res_id);
    bus_rr.res_ready = 1'b1;
    @(negedge clk);
    bus_rr.res_ready = 1'b0;
  endtask

  // fixed-priority instance: both requesters held valid, req1 must never win
  initial begin : fx_proc
    int g0, g1;
    g0 = 0; g1 = 0;
    rst_fx = 1'b0;
    bus_fx.req0_valid = 1'b1; bus_fx.req0_a = 8'h0B; bus_fx.req0_b = 8'h0D;
    bus_fx.req1_valid = 1'b1; bus_fx.req1_a = 8'h21; bus_fx.req1_b = 8'h43;
    bus_fx.res_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_fx = 1'b1;
    repeat (60) begin
      @(negedge clk); #1;
      if (bus_fx.req0_ready) g0++;
      if (bus_fx.req1_ready) g1++;
      if (bus_fx.res_valid) begin
        check("fx_res_id",   bus_fx.res_id,   0);
        check("fx_res_data", bus_fx.res_data, 16'h008F);
      end
    end
    check("fx_req1_grants", g1, 0);
    check("fx_req0_grants_ge9", (g0 >= 9), 1);
    $display("fixed-priority: req0 grants=%0d req1 grants=%0d", g0, g1);
    bus_fx.req0_valid = 1'b0; bus_fx.req1_valid = 1'b0;
    fx_done = 1'b1;
  end

  initial begin : main
    logic [15:0] d;
    logic        rid;
    int          lat, n, got;
    logic [5:0]  step_tab [4];
    logic [15:0] held_data;
    logic        held_id;
    // {sela, selb, sel_shift, data_sel, acc_en} for STEP0..STEP3
    step_tab[0] = 6'b00_00_0_1;
    step_tab[1] = 6'b10_01_1_1;
    step_tab[2] = 6'b01_01_1_1;
    step_tab[3] = 6'b11_10_1_1;

    // ---- reset with both requesters already valid ----
    rst = 1'b0;
    bus_rr.res_ready  = 1'b0;
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h03; bus_rr.req0_b = 8'h05;
    bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'h10; bus_rr.req1_b = 8'h10;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdy0",  bus_rr.req0_ready, 0);
    check("rst_rdy1",  bus_rr.req1_ready, 0);
    check("rst_state", bus_rr.state,      0);
    check("rst_busy",  bus_rr.busy,       0);
    check("rst_rv",    bus_rr.res_valid,  0);
    check("rst_acc_en",bus_rr.acc_en,     0);
    check("rst_op_a",  bus_rr.op_a,       0);
    check("rst_data",  bus_rr.res_data,   0);

    // ---- contention, round robin ----
    @(negedge clk);
    rst = 1'b1;
    bus_rr.res_ready = 1'b1;
    got = 0; n = 0;
    while (got < 2 && n < 60) begin
      @(negedge clk); #1; n++;
      if (bus_rr.res_valid) begin
        if (got == 0) begin
          check("cont_first_data", bus_rr.res_data, 16'h000F);
          check("cont_first_id",   bus_rr.res_id,   0);
        end else begin
          check("cont_second_data", bus_rr.res_data, 16'h0100);
          check("cont_second_id",   bus_rr.res_id,   1);
          bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
        end
        $display("contention result data=%04h rid=%0d", bus_rr.res_data, bus_rr.res_id);
        got++;
      end
    end
    check("cont_count", got, 2);
    @(negedge clk);
    bus_rr.res_ready = 1'b0;

    // ---- step sequencing: req1 12 x 34 ----
    bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'h12; bus_rr.req1_b = 8'h34;
    #1;
    check("seq_rdy1", bus_rr.req1_ready, 1);
    check("seq_rdy0", bus_rr.req0_ready, 0);
    @(negedge clk);
    bus_rr.req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("seq_state", bus_rr.state, k + 1);
      check("seq_ctrl", {bus_rr.sela, bus_rr.selb, bus_rr.sel_shift, bus_rr.data_sel, bus_rr.acc_en},
            step_tab[k]);
      check("seq_op_a", bus_rr.op_a, 8'h12);
      check("seq_op_b", bus_rr.op_b, 8'h34);
      check("seq_busy", bus_rr.busy, 1);
      @(negedge clk);
    end
    #1;
    check("seq_res_state", bus_rr.state,     5);
    check("seq_res_valid", bus_rr.res_valid, 1);
    check("seq_res_data",  bus_rr.res_data,  16'h03A8);
    check("seq_res_id",    bus_rr.res_id,    1);
    check("seq_res_acc_en",bus_rr.acc_en,    0);
    $display("op seq id=1 a=12 b=34 -> data=%04h rid=%0d", bus_rr.res_data, bus_rr.res_id);

    // ---- backpressure: consumer stalls 10 cycles, both requesters waiting ----
    held_data = bus_rr.res_data;
    held_id   = bus_rr.res_id;
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h09; bus_rr.req0_b = 8'h09;
    bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 8'h07; bus_rr.req1_b = 8'h07;
    repeat (10) begin
      @(negedge clk); #1;
      check("bp_rv",   bus_rr.res_valid,  1);
      check("bp_data", bus_rr.res_data,   held_data);
      check("bp_id",   bus_rr.res_id,     held_id);
      check("bp_rdy0", bus_rr.req0_ready, 0);
      check("bp_rdy1", bus_rr.req1_ready, 0);
    end
    bus_rr.res_ready = 1'b1;
    @(negedge clk);
    bus_rr.res_ready = 1'b0;
    #1;
    check("bp_idle_state", bus_rr.state,      0);
    check("bp_resume_rdy0",bus_rr.req0_ready, 1);
    check("bp_resume_rdy1",bus_rr.req1_ready, 0);
    @(negedge clk);
    bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
    finish_result("bp_next", 16'h0051, 1'b0);

    // ---- single product FF x FF ----
    run_op(1'b0, 8'hFF, 8'hFF, d, rid, lat);
    check("ff_data", d,   16'hFE01);
    check("ff_id",   rid, 0);
    check("ff_lat",  lat, 5);

    // ---- reset during STEP2 ----
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 8'h55; bus_rr.req0_b = 8'h66;
    #1;
    check("rmid_rdy0", bus_rr.req0_ready, 1);
    @(negedge clk);
    bus_rr.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rmid_step2", bus_rr.state, 3);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rmid_state",  bus_rr.state,     0);
    check("rmid_busy",   bus_rr.busy,      0);
    check("rmid_rv",     bus_rr.res_valid, 0);
    check("rmid_acc_en", bus_rr.acc_en,    0);
    check("rmid_op_a",   bus_rr.op_a,      0);
    check("rmid_op_b",   bus_rr.op_b,      0);
    check("rmid_ctrl", {bus_rr.sela, bus_rr.selb, bus_rr.sel_shift, bus_rr.data_sel}, 0);
    repeat (4) begin
      @(negedge clk); #1;
      check("rmid_no_rv", bus_rr.res_valid, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 8'h02, 8'h03, d, rid, lat);
    check("rmid_after_data", d,   16'h0006);
    check("rmid_after_lat",  lat, 5);

    // ---- zero operand ----
    run_op(1'b1, 8'h00, 8'h7F, d, rid, lat);
    check("zero_data", d,   0);
    check("zero_id",   rid, 1);
    check("zero_lat",  lat, ZS ? 1 : 5);

    // ---- random traffic against a transaction-level model ----
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    begin : rnd
      int          phase;     // 0 waiting for accept, 1 computing, 2 result offered
      int          cnt;
      bit          fav1;      // model: req1 favoured on contention
      bit          v0, v1, rr, e0, e1;
      logic [7:0]  a0, b0, a1, b1;
      logic [15:0] m_prod;
      bit          m_id;
      int          ops;
      phase = 0; cnt = 0; fav1 = 1'b0; m_prod = '0; m_id = 1'b0; ops = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        v0 = ($urandom % 4) != 0;
        v1 = ($urandom % 4) != 0;
        rr = ($urandom % 3) != 0;
        a0 = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
        b0 = 8'($urandom);
        a1 = 8'($urandom);
        b1 = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
        bus_rr.req0_valid = v0; bus_rr.req0_a = a0; bus_rr.req0_b = b0;
        bus_rr.req1_valid = v1; bus_rr.req1_a = a1; bus_rr.req1_b = b1;
        bus_rr.res_ready  = rr;
        #1;
        if (phase == 0) begin
          e0 = v0 && (!v1 || !fav1);
          e1 = v1 && (!v0 || fav1);
          check("rnd_rdy0", bus_rr.req0_ready, e0);
          check("rnd_rdy1", bus_rr.req1_ready, e1);
          check("rnd_rv_idle", bus_rr.res_valid, 0);
          if (e0 || e1) begin
            m_id   = e1;
            m_prod = e1 ? (16'(a1) * 16'(b1)) : (16'(a0) * 16'(b0));
            fav1   = !e1;
            cnt    = 4;
            phase  = (ZS && (e1 ? (a1 == 0 || b1 == 0) : (a0 == 0 || b0 == 0))) ? 2 : 1;
          end
        end else if (phase == 1) begin
          check("rnd_rdy0_busy", bus_rr.req0_ready, 0);
          check("rnd_rdy1_busy", bus_rr.req1_ready, 0);
          check("rnd_rv_busy",   bus_rr.res_valid,  0);
          cnt--;
          if (cnt == 0) phase = 2;
        end else begin
          check("rnd_rv",   bus_rr.res_valid,  1);
          check("rnd_data", bus_rr.res_data,   m_prod);
          check("rnd_id",   bus_rr.res_id,     m_id);
          check("rnd_rdy_res", {bus_rr.req0_ready, bus_rr.req1_ready}, 0);
          if (rr) begin
            $display("rnd op id=%0d -> data=%04h rid=%0d", m_id, bus_rr.res_data, bus_rr.res_id);
            ops++;
            phase = 0;
          end
        end
        @(negedge clk);
      end
      check("rnd_ops_ge20", (ops >= 20), 1);
      bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0; bus_rr.res_ready = 1'b0;
    end

    n = 0;
    while (!fx_done && n < 200) begin
      @(negedge clk); n++;
    end
    check("fx_done", fx_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
Sequencer and arbiter for the shared nibble-serial 8x8 multiply datapath (operand muxes, 4x4 multiplier, shifter, adder, 16-bit accumulator register).
- Accepts multiply requests from two independent requesters over valid/ready handshakes.
- Arbitrates between them, then drives the four partial-product steps into the datapath.
- Returns the 16-bit product with the requester ID over a valid/ready result port.
- Exports a 3-bit state code for the seven-segment status display.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = req0 always wins.
OP_W, 8, operand width; only 8 is supported (two nibbles per operand).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a, req0_b  input  8 each  requester 0 operands.
req1_valid  input  1  requester 1 has an operation.
req1_ready  output  1  requester 1 operation accepted this cycle.
req1_a, req1_b  input  8 each  requester 1 operands.
op_a, op_b  output  8 each  latched operands to the datapath muxes.
sela, selb  output  1 each  nibble select; 1 = [7:4], 0 = [3:0].
sel_shift  output  2  shifter control; 0 = <<0, 1 = <<4, 2 = <<8.
data_sel  output  1  0 = adder feedback forced to zero; 1 = accumulator feedback.
acc_en  output  1  accumulator register clock enable.
acc_q  input  16  accumulator register output.
res_valid  output  1  product available.
res_ready  input  1  consumer takes the product.
res_id  output  1  ID of the requester that owns the product.
res_data  output  16  product.
busy  output  1  high in any state other than IDLE.
state  output  3  0 = IDLE, 1–4 = STEP0–STEP3, 5 = RESULT.

Behaviour:
- Reset (rst = 0 at a rising edge):
  - FSM returns to IDLE and the round-robin pointer to 0 (req0 favoured).
  - Operand and ID latches clear to 0.
  - All outputs read 0, including both readys, res_valid and acc_en.
  - Both readys are also held 0 combinationally while rst = 0.
  - Reset mid-operation aborts the operation; no result is produced.
- IDLE:
  - Ready is asserted combinationally only to the grantee.
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer's favoured requester is granted (req0 when ROUND_ROBIN = 0).
  - On valid & ready: latch a, b and the ID; go to STEP0.
  - With ROUND_ROBIN = 1, the pointer then moves to favour the other requester.
  - Dropping valid without a handshake is legal and has no effect.
- STEP0–STEP3: one cycle each, acc_en = 1.
  - STEP0: sela 0, selb 0, shift 0, data_sel 0.
  - STEP1: sela 1, selb 0, shift 1, data_sel 1.
  - STEP2: sela 0, selb 1, shift 1, data_sel 1.
  - STEP3: sela 1, selb 1, shift 2, data_sel 1.
  - op_a and op_b hold the latched operands throughout. Steps always run to completion; new requests are not accepted.
- RESULT:
  - res_valid = 1; res_data = acc_q; res_id = latched ID; acc_en = 0.
  - All three are held stable until res_ready = 1, then the FSM goes to IDLE.
- Timing:
  - Latency from request handshake to res_valid is 5 cycles.
  - Minimum spacing between accepts is 6 cycles, because readys are asserted only in IDLE.
  - A result handshake and a new request in the same cycle: the new request is accepted in the following IDLE cycle.
- Outside STEP0–STEP3, acc_en = 0, sela/selb/sel_shift = 0 and data_sel = 0.
- Arithmetic is unsigned; the 16-bit product never overflows.

Optional Feature:
Macro ZERO_SKIP_EN.
- Defined: a latched operand of 0 sends the FSM from IDLE-accept straight to RESULT with res_data forced to 16'h0000; acc_en stays 0, so latency is 1 cycle.
- Undefined: zero operands run all four steps like any other operands.

Test Plan:
- Single product: req0 a = 8'hFF, b = 8'hFF → res_valid at accept+5, res_data 16'hFE01, res_id 0.
- Step sequencing: req1 a = 8'h12, b = 8'h34 → STEP0–STEP3 control values exactly as specified; res_data 16'h03A8, res_id 1.
- Contention: req0 (3, 5) and req1 (8'h10, 8'h10) both held valid from reset, ROUND_ROBIN = 1 → first result 16'h000F id 0, then 16'h0100 id 1. Repeat with ROUND_ROBIN = 0 and req0 held valid → req1 is never granted.
- Backpressure: res_ready held 0 for 10 cycles in RESULT → res_data, res_id and res_valid stable; both readys stay 0; accept resumes the cycle after IDLE is re-entered.
- Reset mid-operation: rst = 0 during STEP2 → next cycle state 0, all outputs 0, no res_valid. After release, a fresh req0 (2, 3) yields 16'h0006.
- Zero skip (with ZERO_SKIP_EN): a = 0, b = 8'h7F → res_valid at accept+1, res_data 0, acc_en never 1. Without the macro → res_valid at accept+5, res_data 0.
